// File: rtl/asteroid_field_stepper.sv
// Asteroid field game stepper: scrolls a LANES x ROWS field on divider-clock edges, tracks player, collisions and score.
// Optional macro ASTEROID_SPEEDUP_EN: steps on both tick edges once score reaches SPEEDUP_SCORE.
module asteroid_field_stepper #(
  parameter int          LANES         = 4,
  parameter int          ROWS          = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned SPEEDUP_SCORE = 32
) (
  input  logic                       cin,
  input  logic                       rst,
  input  logic                       tick_in,
  input  logic                       start,
  input  logic                       move_left,
  input  logic                       move_right,
  output logic [$clog2(LANES)-1:0]   player_lane,
  output logic [LANES*ROWS-1:0]      field,
  output logic [15:0]                score,
  output logic                       game_over,
  output logic                       step_pulse,
  output logic [1:0]                 o_dbg_state
);

  localparam int LW = $clog2(LANES);
  localparam int N  = LANES * ROWS;
  localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [N-1:0]    r_field;
  logic [15:0]     r_score;
  logic [LW-1:0]   r_lane;
  logic [15:0]     r_lfsr;
  logic            r_tick_d;
  logic            r_step_pulse;

  logic            w_rise;
  logic            w_fall;
  logic            w_speedup;
  logic            w_step;
  logic            w_run;
  logic            w_collide;
  logic [LW-1:0]   w_lane_nx;
  logic [LANES-1:0] w_spawn_row;
  logic [N-1:0]    w_field_shift;
  logic [N-1:0]    w_field_nx;
  logic [15:0]     w_lfsr_nx;

  assign w_rise = tick_in & ~r_tick_d;
  assign w_fall = ~tick_in & r_tick_d;

`ifdef ASTEROID_SPEEDUP_EN
  assign w_speedup = ({16'd0, r_score} >= SPEEDUP_SCORE);
`else
  // Speedup disabled: the threshold is referenced but can never enable falling-edge steps.
  assign w_speedup = 1'b0 & ({16'd0, r_score} >= SPEEDUP_SCORE);
`endif

  assign w_step = w_rise | (w_fall & w_speedup);

  // Fibonacci LFSR, taps 16/14/13/11, shifting left with feedback into bit 0.
  assign w_lfsr_nx = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  always_comb begin
    w_spawn_row = '0;
    if (r_lfsr[15]) w_spawn_row[r_lfsr[LW-1:0]] = 1'b1;
  end

  assign w_field_shift = {w_spawn_row, r_field[N-1:LANES]};
  assign w_field_nx    = w_step ? w_field_shift : r_field;

  always_comb begin
    w_lane_nx = r_lane;
    if (move_left && !move_right && r_lane != '0)
      w_lane_nx = r_lane - 1'b1;
    else if (move_right && !move_left && r_lane != LANE_MAX)
      w_lane_nx = r_lane + 1'b1;
  end

  // Collision uses the post-move lane against the post-shift row 0.
  assign w_collide = w_field_nx[w_lane_nx];

  // State register
  always_ff @(posedge cin) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    if (start) begin
      w_state_nx = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nx = ST_IDLE;
        ST_RUN:  if (w_collide) w_state_nx = ST_OVER;
        ST_OVER: w_state_nx = ST_OVER;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    game_over = 1'b0;
    w_run     = 1'b0;
    case (r_state)
      ST_RUN:  w_run     = ~start;
      ST_OVER: game_over = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      r_field      <= '0;
      r_score      <= '0;
      r_lane       <= '0;
      r_lfsr       <= LFSR_SEED;
      r_tick_d     <= 1'b1;
      r_step_pulse <= 1'b0;
    end else begin
      r_tick_d     <= tick_in;
      r_step_pulse <= 1'b0;
      if (start) begin
        r_field <= '0;
        r_score <= '0;
        r_lane  <= '0;
        r_lfsr  <= LFSR_SEED;
      end else if (w_run) begin
        r_lane <= w_lane_nx;
        if (w_step) begin
          r_field      <= w_field_shift;
          r_lfsr       <= w_lfsr_nx;
          r_step_pulse <= 1'b1;
          if (!w_collide && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
        end
      end
    end
  end

  assign field       = r_field;
  assign score       = r_score;
  assign player_lane = r_lane;
  assign step_pulse  = r_step_pulse;
  assign o_dbg_state = r_state;

endmodule
